// File: rtl/soc_evt_rx_buffer.sv
// SoC event receive buffer: FWFT FIFO from a fire-and-forget event stream to a valid/ready sink.
// Optional macro SOC_EVT_RX_DROP_CNT_EN adds a saturating 16-bit dropped-event counter.
module soc_evt_rx_buffer #(
    parameter int EVNT_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       soc_evt_valid_i,
    input  logic [EVNT_WIDTH-1:0]      soc_evt_data_i,
    output logic                       evt_valid_o,
    output logic [EVNT_WIDTH-1:0]      evt_data_o,
    input  logic                       evt_ready_i,
    output logic [$clog2(DEPTH):0]     fill_o,
    output logic                       overflow_o,
    input  logic                       clr_overflow_i,
    output logic [15:0]                drop_cnt_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("soc_evt_rx_buffer: DEPTH must be a power of 2 and >= 2");
    end

    logic [EVNT_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         rd_ptr;
    logic [AW-1:0]         wr_ptr;
    logic [FW-1:0]         fill;
    logic                  overflow;
    logic                  pop;
    logic                  full_eff;
    logic                  push;
    logic                  drop;

    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    always_comb begin
        pop      = (fill != '0) && evt_ready_i;
        full_eff = (fill == FW'(DEPTH)) && !pop;
        push     = soc_evt_valid_i && !full_eff;
        drop     = soc_evt_valid_i && full_eff;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= soc_evt_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
        end
    end

    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_overflow_i) begin
            overflow <= 1'b0;
        end
    end

`ifdef SOC_EVT_RX_DROP_CNT_EN
    logic [15:0] drop_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_cnt <= '0;
        end else if (drop) begin
            if (clr_overflow_i) begin
                drop_cnt <= 16'd1;
            end else if (drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end else if (clr_overflow_i) begin
            drop_cnt <= '0;
        end
    end

    assign drop_cnt_o = drop_cnt;
`else
    assign drop_cnt_o = 16'h0;
`endif

    assign evt_valid_o = (fill != '0);
    assign evt_data_o  = mem[rd_ptr];
    assign fill_o      = fill;
    assign overflow_o  = overflow;

endmodule

// File: tb/tb_soc_evt_rx_buffer.sv
// Self-checking bench for soc_evt_rx_buffer: directed scenarios then random traffic vs a queue model.
module tb_soc_evt_rx_buffer;

    localparam int EW    = 8;
    localparam int DEPTH = 8;
`ifdef SOC_EVT_RX_DROP_CNT_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          soc_evt_valid_i;
    logic [EW-1:0] soc_evt_data_i;
    logic          evt_valid_o;
    logic [EW-1:0] evt_data_o;
    logic          evt_ready_i;
    logic [3:0]    fill_o;
    logic          overflow_o;
    logic          clr_overflow_i;
    logic [15:0]   drop_cnt_o;

    soc_evt_rx_buffer #(.EVNT_WIDTH(EW), .DEPTH(DEPTH)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .soc_evt_valid_i(soc_evt_valid_i),
        .soc_evt_data_i (soc_evt_data_i),
        .evt_valid_o    (evt_valid_o),
        .evt_data_o     (evt_data_o),
        .evt_ready_i    (evt_ready_i),
        .fill_o         (fill_o),
        .overflow_o     (overflow_o),
        .clr_overflow_i (clr_overflow_i),
        .drop_cnt_o     (drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: event queue, sticky flag, saturating drop count.
    logic [EW-1:0] q[$];
    bit            m_ovf;
    int            m_cnt;
    int            n_cmp = 0;
    int            n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs(input string where);
        chk({where, ".valid"}, 32'(evt_valid_o), 32'(q.size() != 0));
        if (q.size() != 0) chk({where, ".data"}, 32'(evt_data_o), 32'(q[0]));
        chk({where, ".fill"}, 32'(fill_o), 32'(q.size()));
        chk({where, ".ovf"}, 32'(overflow_o), 32'(m_ovf));
        chk({where, ".dcnt"}, 32'(drop_cnt_o), DROP_EN ? 32'(m_cnt) : 32'd0);
    endtask

    task automatic step(input bit v, input logic [EW-1:0] d, input bit rdy, input bit clr);
        bit pop, drop;
        @(negedge clk_i);
        chk_outputs("pre");
        soc_evt_valid_i = v;
        soc_evt_data_i  = d;
        evt_ready_i     = rdy;
        clr_overflow_i  = clr;
        #1;
        // outputs must not react combinationally to the new inputs
        chk("nobypass.valid", 32'(evt_valid_o), 32'(q.size() != 0));
        if (q.size() != 0) chk("nobypass.data", 32'(evt_data_o), 32'(q[0]));
        pop  = (q.size() != 0) && rdy;
        drop = v && (q.size() == DEPTH) && !pop;
        if (pop) void'(q.pop_front());
        if (v && !drop) q.push_back(d);
        if (drop) begin
            m_ovf = 1'b1;
            m_cnt = clr ? 1 : (m_cnt == 16'hFFFF ? m_cnt : m_cnt + 1);
        end else if (clr) begin
            m_ovf = 1'b0;
            m_cnt = 0;
        end
    endtask

    initial begin
        rst_ni          = 1'b0;
        soc_evt_valid_i = 1'b0;
        soc_evt_data_i  = '0;
        evt_ready_i     = 1'b0;
        clr_overflow_i  = 1'b0;
        m_ovf           = 1'b0;
        m_cnt           = 0;
        repeat (2) @(negedge clk_i);
        chk("rst.data", 32'(evt_data_o), 32'd0);
        chk_outputs("rst");
        rst_ni = 1'b1;

        // single event, ready held high: visible one cycle later, then gone
        step(1'b1, 8'h11, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // fill to DEPTH, then drop one while full
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        // clear with concurrent drop, then clear alone
        step(1'b1, 8'hCC, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        // full + push + pop: accepted, no overflow; drain to check order
        step(1'b1, 8'hBB, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

        // reset mid-stream discards everything
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
        step(1'b1, 8'h66, 1'b0, 1'b0);
        @(negedge clk_i);
        rst_ni = 1'b0;
        soc_evt_valid_i = 1'b0;
        #1;
        q.delete();
        m_ovf = 1'b0;
        m_cnt = 0;
        chk("midrst.valid", 32'(evt_valid_o), 32'd0);
        chk("midrst.fill", 32'(fill_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        step(1'b1, 8'h3C, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) < 4,
                 $urandom_range(0, 29) == 0);
        end
        @(negedge clk_i);
        chk_outputs("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
